// File: rtl/placar_jogadores.sv
// Multi-player score counter: edge-detected hit/miss per player, saturating score with
// streak bonus, derived blocking lines with change pulse, and latched end-of-game winner.
module placar_jogadores #(
  parameter int N_JOG     = 2,
  parameter int W_PTS     = 6,
  parameter int MAX_PTS   = 32,
  parameter int PASSO     = 4,
  parameter int W_LIN     = 3,
  parameter int SEQ_BONUS = 3,
  localparam int W_VENC   = (N_JOG > 1) ? $clog2(N_JOG) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_JOG-1:0]         acertou,
  input  logic [N_JOG-1:0]         errou,
  output logic [N_JOG*W_PTS-1:0]   pontos,
  output logic [N_JOG*W_LIN-1:0]   linhas_bloq,
  output logic [N_JOG-1:0]         nivel_mudou,
  output logic                     fim_jogo,
  output logic [W_VENC-1:0]        vencedor
);

  localparam int          W_SEQ   = $clog2(SEQ_BONUS);
  localparam int unsigned LIN_CAP = (1 << W_LIN) - 1;

  logic [W_PTS-1:0]       pts_q [N_JOG];
  logic [W_PTS-1:0]       pts_d [N_JOG];
  logic [W_SEQ-1:0]       seq_q [N_JOG];
  logic [W_SEQ-1:0]       seq_d [N_JOG];
  logic [N_JOG-1:0]       ac_ant, er_ant, ev_hit, ev_miss;
  logic [N_JOG*W_LIN-1:0] lin_prev;
  logic                   win_any;
  logic [W_VENC-1:0]      win_idx;

  function automatic logic [W_PTS-1:0] sat_add(input logic [W_PTS-1:0] p, input int unsigned inc);
    int unsigned s;
    s = 32'(p) + inc;
    return (s >= MAX_PTS) ? W_PTS'(MAX_PTS) : W_PTS'(s);
  endfunction

  // Events are gated here so disabled or post-game edges are dropped, never deferred.
  assign ev_hit  = acertou & ~ac_ant & {N_JOG{enable & ~fim_jogo}};
  assign ev_miss = errou   & ~er_ant & {N_JOG{enable & ~fim_jogo}};

  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < N_JOG; i++) begin
      pts_d[i] = pts_q[i];
      seq_d[i] = seq_q[i];
      if (ev_hit[i] && ev_miss[i]) begin
        seq_d[i] = '0;
      end else if (ev_hit[i]) begin
        if (32'(seq_q[i]) + 1 == SEQ_BONUS) begin
          seq_d[i] = '0;
          pts_d[i] = sat_add(pts_q[i], 2);
        end else begin
          seq_d[i] = seq_q[i] + 1'b1;
          pts_d[i] = sat_add(pts_q[i], 1);
        end
      end else if (ev_miss[i]) begin
        seq_d[i] = '0;
        pts_d[i] = (pts_q[i] == '0) ? '0 : pts_q[i] - 1'b1;
      end
      if (!win_any && 32'(pts_d[i]) == MAX_PTS) begin
        win_any = 1'b1;
        win_idx = W_VENC'(i);
      end
    end
  end

  always_comb begin
    pontos      = '0;
    linhas_bloq = '0;
    for (int unsigned i = 0; i < N_JOG; i++) begin
      pontos[i*W_PTS +: W_PTS] = pts_q[i];
      linhas_bloq[i*W_LIN +: W_LIN] = (32'(pts_q[i]) / PASSO > LIN_CAP) ?
                                      W_LIN'(LIN_CAP) : W_LIN'(32'(pts_q[i]) / PASSO);
    end
  end

  always_ff @(posedge clk) begin
    ac_ant <= acertou;
    er_ant <= errou;
    if (reset) begin
      for (int unsigned i = 0; i < N_JOG; i++) begin
        pts_q[i] <= '0;
        seq_q[i] <= '0;
      end
      lin_prev    <= '0;
      nivel_mudou <= '0;
      fim_jogo    <= 1'b0;
      vencedor    <= '0;
    end else begin
      for (int unsigned i = 0; i < N_JOG; i++) begin
        pts_q[i]       <= pts_d[i];
        seq_q[i]       <= seq_d[i];
        nivel_mudou[i] <= (linhas_bloq[i*W_LIN +: W_LIN] != lin_prev[i*W_LIN +: W_LIN]);
      end
      lin_prev <= linhas_bloq;
      if (!fim_jogo && win_any) begin
        fim_jogo <= 1'b1;
        vencedor <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_placar_jogadores.sv
// Bench for placar_jogadores: default 2-player instance against an integer score model,
// plus a 4-player instance with a small line cap for slicing and capping.
module tb_placar_jogadores;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable;
  logic [1:0]  acertou, errou;
  logic [11:0] pontos;
  logic [5:0]  linhas_bloq;
  logic [1:0]  nivel_mudou;
  logic        fim_jogo;
  logic [0:0]  vencedor;

  logic        reset_b, enable_b;
  logic [3:0]  ac_b, er_b;
  logic [23:0] pontos_b;
  logic [7:0]  lin_b;
  logic [3:0]  niv_b;
  logic        fim_b;
  logic [1:0]  venc_b;

  placar_jogadores dut (
    .clk(clk), .reset(reset), .enable(enable), .acertou(acertou), .errou(errou),
    .pontos(pontos), .linhas_bloq(linhas_bloq), .nivel_mudou(nivel_mudou),
    .fim_jogo(fim_jogo), .vencedor(vencedor)
  );

  placar_jogadores #(.N_JOG(4), .PASSO(3), .W_LIN(2)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .acertou(ac_b), .errou(er_b),
    .pontos(pontos_b), .linhas_bloq(lin_b), .nivel_mudou(niv_b),
    .fim_jogo(fim_b), .vencedor(venc_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model for the default instance: plain integer scores and streaks.
  int         m_pts [2];
  int         m_seq [2];
  int         m_lin_last [2];
  logic [1:0] m_niv, m_acp, m_erp;
  logic       m_fim;
  int         m_venc;

  function automatic int lin_a(input int s);
    return (s / 4 > 7) ? 7 : s / 4;
  endfunction

  function automatic logic [11:0] exp_pontos();
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) r[i*6 +: 6] = 6'(m_pts[i]);
    return r;
  endfunction

  function automatic logic [5:0] exp_lin();
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 2; i++) r[i*3 +: 3] = 3'(lin_a(m_pts[i]));
    return r;
  endfunction

  task automatic model_step(input logic [1:0] a, input logic [1:0] e, input logic en, input logic rst);
    logic hit, miss;
    bit   won;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_pts[i] = 0; m_seq[i] = 0; m_lin_last[i] = 0;
      end
      m_niv = '0; m_fim = 1'b0; m_venc = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_niv[i] = (lin_a(m_pts[i]) != m_lin_last[i]);
        m_lin_last[i] = lin_a(m_pts[i]);
      end
      won = 0;
      for (int i = 0; i < 2; i++) begin
        hit  = a[i] && !m_acp[i] && en && !m_fim;
        miss = e[i] && !m_erp[i] && en && !m_fim;
        if (hit && miss) m_seq[i] = 0;
        else if (hit) begin
          m_seq[i]++;
          if (m_seq[i] == 3) begin m_seq[i] = 0; m_pts[i] += 2; end
          else m_pts[i] += 1;
          if (m_pts[i] > 32) m_pts[i] = 32;
        end else if (miss) begin
          m_seq[i] = 0;
          if (m_pts[i] > 0) m_pts[i]--;
        end
      end
      for (int i = 0; i < 2; i++)
        if (!m_fim && !won && m_pts[i] == 32) begin won = 1; m_venc = i; end
      if (won) m_fim = 1'b1;
    end
    m_acp = a;
    m_erp = e;
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] e, input logic en, input logic rst);
    acertou = a; errou = e; enable = en; reset = rst;
    model_step(a, e, en, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] a, e;
    a = 2'($urandom); e = 2'($urandom);
    drive(a, e, 1'b1, 1'b1);
    drive(a, e, 1'b1, 1'b1);
    tests++;
    if ({pontos, linhas_bloq, nivel_mudou, fim_jogo, vencedor} !== '0) begin
      fails++;
      $display("FAIL reset_state: got pts=%h lin=%h niv=%b fim=%b venc=%h want all zero",
               pontos, linhas_bloq, nivel_mudou, fim_jogo, vencedor);
    end
    drive(a, e, 1'b1, 1'b0);
    tests++;
    if (pontos !== 12'h000) begin
      fails++; $display("FAIL reset_held_levels: got pts=%h want 000", pontos);
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_bonus();
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(2'b01, 2'b00, 1'b1, 1'b0);
      drive(2'b00, 2'b00, 1'b1, 1'b0);
    end
    tests++;
    if (pontos[5:0] !== 6'd2) begin
      fails++; $display("FAIL bonus_two_hits: got %0d want 2", pontos[5:0]);
    end
    drive(2'b01, 2'b00, 1'b1, 1'b0);
    tests++;
    if (pontos[5:0] !== 6'd4 || linhas_bloq[2:0] !== 3'd1 || nivel_mudou[0] !== 1'b0) begin
      fails++;
      $display("FAIL bonus_third_hit: got pts=%0d lin=%0d niv=%b want 4 1 0",
               pontos[5:0], linhas_bloq[2:0], nivel_mudou[0]);
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    tests++;
    if (nivel_mudou !== 2'b01) begin
      fails++; $display("FAIL bonus_nivel_pulse: got %b want 01", nivel_mudou);
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    tests++;
    if (nivel_mudou !== 2'b00) begin
      fails++; $display("FAIL bonus_nivel_one_cycle: got %b want 00", nivel_mudou);
    end
    drive(2'b01, 2'b00, 1'b1, 1'b0);
    tests++;
    if (pontos !== exp_pontos() || pontos[5:0] !== 6'd5) begin
      fails++; $display("FAIL bonus_streak_reset: got %h want %h", pontos, exp_pontos());
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) drive(2'b10, 2'b00, 1'b1, 1'b0);
    tests++;
    if (pontos[11:6] !== 6'd1) begin
      fails++; $display("FAIL hold_single_event: got %0d want 1", pontos[11:6]);
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 2'b10, 1'b1, 1'b0);
      drive(2'b00, 2'b00, 1'b1, 1'b0);
    end
    tests++;
    if (pontos !== 12'h000 || pontos !== exp_pontos()) begin
      fails++; $display("FAIL miss_floor: got %h want 000", pontos);
    end
  endtask

  task automatic test_simul();
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 2'b00, 1'b1, 1'b0);
      drive(2'b00, 2'b00, 1'b1, 1'b0);
    end
    drive(2'b11, 2'b01, 1'b1, 1'b0);
    tests++;
    if (pontos[5:0] !== 6'd5 || pontos[11:6] !== 6'd1) begin
      fails++; $display("FAIL simul_hit_miss: got p0=%0d p1=%0d want 5 1", pontos[5:0], pontos[11:6]);
    end
    for (int k = 0; k < 2; k++) begin
      drive(2'b00, 2'b00, 1'b1, 1'b0);
      drive(2'b01, 2'b00, 1'b1, 1'b0);
    end
    tests++;
    if (pontos[5:0] !== 6'd7 || pontos !== exp_pontos()) begin
      fails++; $display("FAIL simul_streak_cleared: got p0=%0d want 7", pontos[5:0]);
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_endgame();
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 40 && m_pts[0] != 30; k++) begin
      drive(2'b11, 2'b00, 1'b1, 1'b0);
      drive(2'b00, 2'b00, 1'b1, 1'b0);
    end
    drive(2'b00, 2'b11, 1'b1, 1'b0);
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 2'b00, 1'b1, 1'b0);
      drive(2'b00, 2'b00, 1'b1, 1'b0);
    end
    tests++;
    if (pontos !== {6'd31, 6'd31} || fim_jogo !== 1'b0) begin
      fails++; $display("FAIL endgame_setup: got pts=%h fim=%b want 7df 0", pontos, fim_jogo);
    end
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    tests++;
    if (pontos !== {6'd32, 6'd32} || fim_jogo !== 1'b1 || vencedor !== 1'b0) begin
      fails++; $display("FAIL endgame_win: got pts=%h fim=%b venc=%0d want 820 1 0",
                        pontos, fim_jogo, vencedor);
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    drive(2'b00, 2'b11, 1'b1, 1'b0);
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    drive(2'b11, 2'b00, 1'b1, 1'b0);
    tests++;
    if (pontos !== {6'd32, 6'd32} || fim_jogo !== 1'b1 || vencedor !== 1'b0) begin
      fails++; $display("FAIL endgame_frozen: got pts=%h fim=%b venc=%0d want 820 1 0",
                        pontos, fim_jogo, vencedor);
    end
    drive(2'b11, 2'b00, 1'b1, 1'b1);
    tests++;
    if ({pontos, linhas_bloq, nivel_mudou, fim_jogo, vencedor} !== '0) begin
      fails++; $display("FAIL endgame_reset: got pts=%h lin=%h niv=%b fim=%b want all zero",
                        pontos, linhas_bloq, nivel_mudou, fim_jogo);
    end
  endtask

  task automatic test_enable();
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    drive(2'b01, 2'b00, 1'b1, 1'b0);
    tests++;
    if (pontos !== 12'h000) begin
      fails++; $display("FAIL enable_discard: got %h want 000", pontos);
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    drive(2'b01, 2'b00, 1'b1, 1'b0);
    tests++;
    if (pontos !== 12'h001 || pontos !== exp_pontos()) begin
      fails++; $display("FAIL enable_fresh_edge: got %h want 001", pontos);
    end
  endtask

  task automatic test_random();
    logic [1:0] a, e;
    logic en, rst;
    int bad = 0;
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 600; k++) begin
      a   = 2'($urandom);
      e   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 99) == 0);
      drive(a, e, en, rst);
      tests++;
      if (pontos !== exp_pontos() || linhas_bloq !== exp_lin() || nivel_mudou !== m_niv ||
          fim_jogo !== m_fim || (m_fim && vencedor !== 1'(m_venc))) begin
        fails++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle%0d: got pts=%h lin=%h niv=%b fim=%b venc=%0d want %h %h %b %b %0d",
                   k, pontos, linhas_bloq, nivel_mudou, fim_jogo, vencedor,
                   exp_pontos(), exp_lin(), m_niv, m_fim, m_venc);
      end
    end
  endtask

  task automatic tick_b(input logic [3:0] a);
    ac_b = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_param_slice();
    int s = 0, q = 0, lw;
    reset_b = 1'b1;
    tick_b(4'b0000);
    reset_b = 1'b0;
    tick_b(4'b0000);
    for (int k = 0; k < 9; k++) begin
      tick_b(4'b1000);
      q++;
      if (q == 3) begin q = 0; s += 2; end else s += 1;
      lw = (s / 3 > 3) ? 3 : s / 3;
      tests++;
      if (pontos_b[23:18] !== 6'(s) || lin_b[7:6] !== 2'(lw)) begin
        fails++; $display("FAIL param_p3_step%0d: got pts=%0d lin=%0d want %0d %0d",
                          k, pontos_b[23:18], lin_b[7:6], s, lw);
      end
      tick_b(4'b0000);
    end
    tests++;
    if (pontos_b !== {6'd12, 18'd0} || lin_b !== 8'b1100_0000) begin
      fails++; $display("FAIL param_cap_slice: got pts=%h lin=%b want 300000 11000000", pontos_b, lin_b);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; acertou = '0; errou = '0;
    reset_b = 1'b1; enable_b = 1'b1; ac_b = '0; er_b = '0;
    m_acp = '0; m_erp = '0; m_niv = '0; m_fim = 1'b0; m_venc = 0;
    for (int i = 0; i < 2; i++) begin m_pts[i] = 0; m_seq[i] = 0; m_lin_last[i] = 0; end
    @(posedge clk);
    #1;
    test_reset();
    test_bonus();
    test_hold();
    test_simul();
    test_endgame();
    test_enable();
    test_random();
    test_param_slice();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/placar_jogadores.md
# placar_jogadores

Multi-player score counter for the game datapath, generalising the single-player points/blocking-line counter. Each player channel counts hit/miss events with internal edge detection, saturating arithmetic and a consecutive-hit bonus. It derives a per-player number of blocking lines from the score and pulses when that number changes. It latches end-of-game and the winner when any player reaches the maximum score; the rendering and game-control FSMs consume these outputs.

## Interface
- N_JOG, default 2: number of player channels (1..8).
- W_PTS, default 6: score width per player.
- MAX_PTS, default 32: saturation ceiling and winning score (must be < 2^W_PTS).
- PASSO, default 4: points per blocking line.
- W_LIN, default 3: blocking-line count width; cap = 2^W_LIN − 1.
- SEQ_BONUS, default 3: consecutive hits that earn +2 instead of +1 (≥2).

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when high, detected events update scores.
- acertou  in  N_JOG  per-player hit level; bit i = player i.
- errou  in  N_JOG  per-player miss level.
- pontos  out  N_JOG*W_PTS  registered scores; player i at [i*W_PTS +: W_PTS].
- linhas_bloq  out  N_JOG*W_LIN  blocking lines; player i at [i*W_LIN +: W_LIN].
- nivel_mudou  out  N_JOG  one-cycle pulse when player i's linhas_bloq changed.
- fim_jogo  out  1  latched high once any player reaches MAX_PTS.
- vencedor  out  $clog2(N_JOG) (min 1)  index of winning player, valid while fim_jogo.

## Operation
- Edge detection per player: hit event = acertou[i] & ~acertou_ant[i]; likewise for miss. The *_ant registers sample the inputs every cycle, including while reset or enable is low. A level held high produces exactly one event.
- An event counts only if enable=1 and fim_jogo=0. Otherwise it is discarded, not deferred.
- Hit and miss events in the same cycle for one player: no score change; the streak is cleared.
- Hit: seq[i] increments. If the new seq equals SEQ_BONUS, the increment is 2 and seq resets to 0; otherwise the increment is 1. The result saturates at MAX_PTS.
- Miss: score − 1, floored at 0; seq[i] cleared, including when the score is already 0.
- Players are fully independent; simultaneous events on different players all apply in the same cycle.
- linhas_bloq[i] = min(pontos[i] / PASSO, 2^W_LIN − 1), computed combinationally from the registered score. With defaults: 0–3→0, 4–7→1, …, 28–32→7.
- nivel_mudou[i] is registered: high for one cycle after any edge at which linhas_bloq[i] differs from its value at the previous edge.
- End of game: at the first edge where any updated score equals MAX_PTS, fim_jogo←1 and vencedor←that index. If several players reach MAX_PTS in the same cycle, the lowest index wins. All scores are then frozen until reset.
- Reset: pontos=0, seq=0, linhas_bloq=0, nivel_mudou=0, fim_jogo=0, vencedor=0. The *_ant registers load the current inputs, so levels held across reset do not generate events.

## Timing
- Input sampled high at edge k (low at k−1) → pontos and linhas_bloq hold the new value after edge k (1-cycle latency).
- nivel_mudou rises after edge k+1 and stays high exactly one cycle.
- fim_jogo and vencedor update at the same edge as the winning score.
- Reset asserted mid-game takes priority at that edge over any event in the same cycle.
- Minimum event spacing is 2 cycles per input: a low, then a high sample.

## Test plan
- Defaults, player 0 hit pulses ×2, single-cycle spacing with low between → pontos0=2, seq0=2. Third hit → pontos0=4 (bonus), seq0=0, linhas_bloq0=1, nivel_mudou0 pulses one cycle after.
- acertou[1] held high 10 cycles → pontos1=1 only. Then errou[1] pulse ×3 → pontos1=0, no underflow.
- Same-cycle rising acertou[0] and errou[0] with pontos0=5 → pontos0 stays 5, seq0=0. Same cycle, hit on player 1 → pontos1 increments normally.
- Player 0 at 31, player 1 at 31, both hit in the same cycle → both 32, fim_jogo=1, vencedor=0. Further events ignored and scores frozen. reset → all outputs 0.
- enable=0 during hit pulses → no change. Raise enable while acertou is still high → no event. A fresh edge then counts.
- Parameters N_JOG=4, PASSO=3, W_LIN=2, pontos=12 → linhas_bloq=3 (capped). Verify packed-bus slicing for player 3.
